// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC fetch/hold/update sequencer with next-PC arbitration; fetch watchdog under PCSEQ_TIMEOUT_EN
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h00400020,
    parameter logic [31:0] EXC_VEC     = 32'h80000180,
    parameter int          WAIT_CYCLES = 2,
    parameter int          TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_idx,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    output logic        imem_req,
    output logic        pc_en,
    output logic [31:0] pc_next,
    output logic [31:0] epc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {FETCH, HOLD, UPDATE} state_t;

    // One counter serves both the HOLD wait and the FETCH watchdog, so size it for the larger.
    localparam int CNT_MAX = (WAIT_CYCLES > TIMEOUT) ? WAIT_CYCLES : TIMEOUT;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          exc_pend;
    logic          take_exc;
    logic [31:0]   pc4;
    logic [31:0]   target;

    always_comb begin
        pc4      = pc + 32'd4;
        take_exc = exc | exc_pend;
        target   = pc4;
        if (take_exc)
            target = EXC_VEC;
        else if (jr)
            target = jr_target;
        else if (jump)
            target = {pc4[31:28], jump_idx, 2'b00};
        else if (branch_taken)
            target = pc4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            pc_en     <= 1'b0;
            pc_next   <= RESET_PC;
            epc       <= 32'd0;
            fetch_err <= 1'b0;
            cnt       <= '0;
            exc_pend  <= 1'b0;
        end else begin
            pc_en     <= 1'b0;
            fetch_err <= 1'b0;
            if (exc)
                exc_pend <= 1'b1;
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        state    <= HOLD;
                        imem_req <= 1'b0;
                        cnt      <= '0;
                    end
`ifdef PCSEQ_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        fetch_err <= 1'b1;
                        pc_en     <= 1'b1;
                        pc_next   <= EXC_VEC;
                        epc       <= pc;
                        imem_req  <= 1'b0;
                        cnt       <= '0;
                        state     <= UPDATE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                HOLD: begin
                    if (cnt != WAIT_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else if (!stall) begin
                        pc_next <= target;
                        pc_en   <= 1'b1;
                        cnt     <= '0;
                        state   <= UPDATE;
                        // Clearing here overrides a same-edge exc set above: it is consumed now.
                        if (take_exc) begin
                            epc      <= pc;
                            exc_pend <= 1'b0;
                        end
                    end
                end
                UPDATE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with randomized transactions
module tb_pc_sequencer;

    localparam int          W        = 2;
    localparam logic [31:0] RESET_PC = 32'h00400020;
    localparam logic [31:0] EXC_VEC  = 32'h80000180;
    localparam int          NONE     = -100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'd0;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = 16'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_idx = 26'd0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        exc = 1'b0;
    logic        imem_req;
    logic        pc_en;
    logic [31:0] pc_next;
    logic [31:0] epc;
    logic        fetch_err;

    pc_sequencer #(
        .RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC), .WAIT_CYCLES(W), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc), .imem_ready(imem_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_imm(branch_imm), .jump(jump),
        .jump_idx(jump_idx), .jr(jr), .jr_target(jr_target), .exc(exc),
        .imem_req(imem_req), .pc_en(pc_en), .pc_next(pc_next), .epc(epc),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] nxt;
        logic [31:0] epc;
        int          cycle;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_epc = 32'd0;
    bit          m_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] p, input bit take,
            input bit j_r, input logic [31:0] jt, input bit jmp, input logic [25:0] idx,
            input bit br, input logic [15:0] imm);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (take) return EXC_VEC;
        if (j_r) return jt;
        if (jmp) return (seq & 32'hF000_0000) | (32'(idx) * 32'd4);
        if (br) return seq + 32'(int'($signed(imm)) * 4);
        return seq;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction: d idle FETCH cycles, ready, then s stalled cycles after the ready edge.
    task automatic run_txn(input logic [31:0] t_pc, input int d, input int s, input int exc_at,
            input bit exc_carry, input bit t_jr, input logic [31:0] t_jrt, input bit t_jump,
            input logic [25:0] t_idx, input bit t_br, input logic [15:0] t_imm,
            output logic [31:0] nxt);
        int k;
        bit take;
        k = (s + 1 > W) ? s + 1 : W;
        take = m_pend || (exc_at >= -d && exc_at <= k);
        nxt = ref_next(t_pc, take, t_jr, t_jrt, t_jump, t_idx, t_br, t_imm);
        pc = t_pc; jr = t_jr; jr_target = t_jrt; jump = t_jump; jump_idx = t_idx;
        branch_taken = t_br; branch_imm = t_imm;
        for (int rel = -d; rel <= k; rel++) begin
            imem_ready = (rel == 0) || (rel > 0 && $urandom_range(0, 1) == 1);
            stall = (rel >= 1 && rel <= s) || (rel <= 0 && $urandom_range(0, 1) == 1);
            exc = (rel == exc_at);
            step();
            if (rel == 0) begin
                if (take) m_epc = t_pc;
                sb.push_back('{nxt, m_epc, cyc + k});
                m_pend = 1'b0;
            end
        end
        imem_ready = $urandom_range(0, 1) == 1;
        stall = $urandom_range(0, 1) == 1;
        exc = exc_carry;
        step();
        m_pend = exc_carry;
        imem_ready = 1'b0; stall = 1'b0; exc = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && pc_en) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pc_en: pc_en=1 at cycle %0d, required no update pending", cyc);
            end else begin
                e = sb.pop_front();
                chk("pc_next", pc_next, e.nxt);
                chk("epc", epc, e.epc);
                chk("pc_en_cycle", 32'(cyc), 32'(e.cycle));
                chk("imem_req_in_update", 32'(imem_req), 32'd0);
                chk("fetch_err", 32'(fetch_err), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] nxt;
        logic [31:0] p;
        int d, s, ea;

        reset = 1'b1;
        step(); step();
        chk("reset_imem_req", 32'(imem_req), 32'd1);
        chk("reset_pc_en", 32'(pc_en), 32'd0);
        chk("reset_pc_next", pc_next, RESET_PC);
        chk("reset_epc", epc, 32'd0);
        chk("reset_fetch_err", 32'(fetch_err), 32'd0);
        reset = 1'b0;

        run_txn(32'h00400020, 0, 0, NONE, 0, 0, 0, 0, 0, 0, 16'h0, nxt);
        run_txn(32'h00400028, 1, 0, NONE, 0, 0, 0, 0, 0, 1, 16'hFFFF, nxt);
        run_txn(32'hFFFFFFFC, 0, 0, NONE, 0, 0, 0, 0, 0, 0, 16'h0, nxt);
        run_txn(32'h00400100, 2, 0, -1, 0, 0, 0, 1, 26'h0123456, 0, 16'h0, nxt);
        run_txn(32'h00400200, 0, 5, NONE, 0, 0, 0, 0, 0, 0, 16'h0, nxt);
        run_txn(32'h00400300, 1, 0, NONE, 0, 1, 32'h1234_5678, 1, 26'h3FFFFFF, 1, 16'h0010, nxt);
        run_txn(32'h70400300, 0, 0, NONE, 0, 0, 0, 1, 26'h3FFFFFF, 1, 16'h0010, nxt);
        run_txn(32'h00400400, 0, 3, 4, 0, 1, 32'hDEAD_BEE0, 0, 0, 0, 16'h0, nxt);
        run_txn(32'h00400500, 1, 0, NONE, 1, 0, 0, 0, 0, 1, 16'h7FFF, nxt);
        run_txn(32'h00400600, 0, 0, NONE, 0, 0, 0, 1, 26'h0000040, 0, 16'h0, nxt);

        // Reset in HOLD with an exception pending: the exception must be dropped.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; exc = 1'b1;
        step();
        exc = 1'b0; reset = 1'b1;
        step();
        chk("midreset_imem_req", 32'(imem_req), 32'd1);
        chk("midreset_pc_next", pc_next, RESET_PC);
        chk("midreset_epc", epc, 32'd0);
        reset = 1'b0;
        m_epc = 32'd0; m_pend = 1'b0;
        run_txn(32'h00400700, 0, 0, NONE, 0, 0, 0, 0, 0, 0, 16'h0, nxt);

        for (int i = 0; i < 40; i++) begin
            p = ($urandom_range(0, 3) == 0) ? $urandom : nxt;
            d = $urandom_range(0, 2);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            ea = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, d + W)) - d : NONE;
            run_txn(p, d, s, ea, (i < 39) && ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 3) == 0, $urandom,
                    $urandom_range(0, 3) == 0, 26'($urandom),
                    $urandom_range(0, 3) == 0, 16'($urandom), nxt);
        end

        repeat (5) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
